// File: rtl/rule_conf_pkg.sv
// Shared encodings for the parser rule configuration bank: address layout,
// region codes and the commit state machine states.
package rule_conf_pkg;

    localparam logic [1:0] REG_TOFF = 2'b00;
    localparam logic [1:0] REG_RULE = 2'b01;
    localparam logic [1:0] REG_TYPE = 2'b10;
    localparam logic [1:0] REG_KEY  = 2'b11;

    localparam logic [31:0] CTRL_ADDR = 32'h8000_0000;

    localparam int unsigned CTRL_BIT   = 31;
    localparam int unsigned STAGE_LSB  = 20;
    localparam int unsigned STAGE_W    = 4;
    localparam int unsigned REGION_LSB = 16;
    localparam int unsigned REGION_W   = 2;
    localparam int unsigned IDX_LSB    = 0;
    localparam int unsigned IDX_W      = 6;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        APPLY
    } commit_state_e;

    // Number of valid entries addressable in a given region of one stage.
    function automatic int unsigned region_limit(
        input logic [1:0]  region,
        input int unsigned type_num,
        input int unsigned rule_num,
        input int unsigned key_num
    );
        int unsigned lim;
        case (region)
            REG_TOFF: lim = type_num;
            REG_RULE: lim = rule_num;
            REG_TYPE: lim = type_num;
            default:  lim = key_num;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/rule_conf_decode.sv
// Combinational register-bus address decoder: splits the address into stage,
// region and index, and flags whether the access targets a real register.
module rule_conf_decode
    import rule_conf_pkg::*;
#(
    parameter int unsigned STAGE_NUM     = 3,
    parameter int unsigned TYPE_NUM      = 4,
    parameter int unsigned KEY_FIELD_NUM = 8,
    parameter int unsigned RULE_NUM      = 4
) (
    input  logic [31:0]         addr,
    output logic [STAGE_W-1:0]  stage,
    output logic [REGION_W-1:0] region,
    output logic [IDX_W-1:0]    idx,
    output logic                ctrl_space,
    output logic                ctrl_hit,
    output logic                legal
);

    logic in_range;

    assign stage      = addr[STAGE_LSB +: STAGE_W];
    assign region     = addr[REGION_LSB +: REGION_W];
    assign idx        = addr[IDX_LSB +: IDX_W];
    assign ctrl_space = addr[CTRL_BIT];
    assign ctrl_hit   = (addr == CTRL_ADDR);

    assign in_range = (32'(stage) < STAGE_NUM) &&
                      (32'(idx) < region_limit(region, TYPE_NUM, RULE_NUM, KEY_FIELD_NUM));

    // Only the single control register is legal inside the control space.
    assign legal = ctrl_space ? ctrl_hit : in_range;

endmodule

// File: rtl/rule_conf_bank.sv
// Parser configuration bank: register-bus decode into per-stage type offsets
// (double-buffered, committed when stages are idle), type rules and key offsets.
module rule_conf_bank
    import rule_conf_pkg::*;
#(
    parameter int unsigned STAGE_NUM         = 3,
    parameter int unsigned TYPE_OFFSET_WIDTH = 7,
    parameter int unsigned TYPE_NUM          = 4,
    parameter int unsigned TYPE_WIDTH        = 8,
    parameter int unsigned KEY_OFFSET_WIDTH  = 6,
    parameter int unsigned KEY_FIELD_NUM     = 8,
    parameter int unsigned RULE_NUM          = 4
) (
    input  logic                                                  i_clk,
    input  logic                                                  i_rst_n,
    input  logic                                                  i_rule_wren,
    input  logic                                                  i_rule_rden,
    input  logic [31:0]                                           i_rule_addr,
    input  logic [31:0]                                           i_rule_wdata,
    output logic [31:0]                                           o_rule_rdata,
    output logic                                                  o_rule_rvalid,
    output logic                                                  o_rule_err,
    input  logic [STAGE_NUM-1:0]                                  i_stage_idle,
    output logic                                                  o_commit_busy,
    output logic                                                  o_commit_done,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] o_type_offset,
    output logic [STAGE_NUM-1:0][RULE_NUM-1:0]                    o_typeRule_wren,
    output logic [STAGE_NUM-1:0]                                  o_typeRule_valid,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]    o_typeRule_typeData,
    output logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]    o_typeRule_typeMask,
    output logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset
);

    logic [STAGE_W-1:0]  stage;
    logic [REGION_W-1:0] region;
    logic [IDX_W-1:0]    idx;
    logic                ctrl_space;
    logic                ctrl_hit;
    logic                legal;
    logic [31:0]         stage_ext;
    logic [31:0]         idx_ext;

    rule_conf_decode #(
        .STAGE_NUM     (STAGE_NUM),
        .TYPE_NUM      (TYPE_NUM),
        .KEY_FIELD_NUM (KEY_FIELD_NUM),
        .RULE_NUM      (RULE_NUM)
    ) u_decode (
        .addr       (i_rule_addr),
        .stage      (stage),
        .region     (region),
        .idx        (idx),
        .ctrl_space (ctrl_space),
        .ctrl_hit   (ctrl_hit),
        .legal      (legal)
    );

    assign stage_ext = 32'(stage);
    assign idx_ext   = 32'(idx);

    // Registers
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]    shadow_q;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]    active_q;
    logic [STAGE_NUM-1:0][RULE_NUM-1:0]                           wren_q;
    logic [STAGE_NUM-1:0]                                         valid_q;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]           type_data_q;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]           type_mask_q;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_off_q;
    logic [31:0]                                                  rdata_q;
    logic                                                         rvalid_q;
    logic                                                         err_q;
    commit_state_e                                                state_q, state_d;
    logic [STAGE_NUM-1:0]                                         mask_q, mask_d;

    // Access qualification; a simultaneous write drops the read.
    logic wr_en;
    logic rd_en;
    logic bank_wr;
    logic commit_req;
    logic commit_ok;
    logic err_d;
    logic apply;
    logic unused_wdata;

    assign wr_en      = i_rule_wren;
    assign rd_en      = i_rule_rden & ~i_rule_wren;
    assign bank_wr    = wr_en & legal & ~ctrl_space;
    assign commit_req = wr_en & ctrl_hit;
    assign commit_ok  = commit_req & (state_q == IDLE) & (|i_rule_wdata[STAGE_NUM-1:0]);
    assign err_d      = (wr_en & ~legal) | (commit_req & ~commit_ok) | (rd_en & ~legal);

    assign unused_wdata = ^i_rule_wdata;

    // Commit FSM next-state
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        apply   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_ok) begin
                    state_d = WAIT;
                    mask_d  = i_rule_wdata[STAGE_NUM-1:0];
                end
            end
            WAIT: begin
                if ((i_stage_idle & mask_q) == mask_q) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                apply   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    // Type offsets: the active copy samples the pre-write shadow on APPLY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                for (int unsigned i = 0; i < TYPE_NUM; i++) begin
                    if (bank_wr && region == REG_TOFF && stage_ext == s && idx_ext == i) begin
                        shadow_q[s][i] <= i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
                    end
                end
                if (apply && mask_q[s]) begin
                    active_q[s] <= shadow_q[s];
                end
            end
        end
    end

    // Rule staging registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wren_q      <= '0;
            valid_q     <= '0;
            type_data_q <= '0;
            type_mask_q <= '0;
            key_off_q   <= '0;
        end else begin
            wren_q <= '0;
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                if (bank_wr && stage_ext == s) begin
                    for (int unsigned i = 0; i < RULE_NUM; i++) begin
                        if (region == REG_RULE && idx_ext == i) begin
                            valid_q[s]    <= i_rule_wdata[0];
                            wren_q[s][i]  <= 1'b1;
                        end
                    end
                    for (int unsigned i = 0; i < TYPE_NUM; i++) begin
                        if (region == REG_TYPE && idx_ext == i) begin
                            type_data_q[s][i] <= i_rule_wdata[16 +: TYPE_WIDTH];
                            type_mask_q[s][i] <= i_rule_wdata[0 +: TYPE_WIDTH];
                        end
                    end
                    for (int unsigned i = 0; i < KEY_FIELD_NUM; i++) begin
                        if (region == REG_KEY && idx_ext == i) begin
                            key_off_q[s][i] <= i_rule_wdata[0 +: KEY_OFFSET_WIDTH];
                        end
                    end
                end
            end
        end
    end

    // Readback mux
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        if (ctrl_hit) begin
            rd_val = {(state_q != IDLE), {(31 - STAGE_NUM){1'b0}}, mask_q};
        end else if (legal) begin
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                if (stage_ext == s) begin
                    unique case (region)
                        REG_TOFF: begin
                            for (int unsigned i = 0; i < TYPE_NUM; i++) begin
                                if (idx_ext == i) rd_val = 32'(shadow_q[s][i]);
                            end
                        end
                        REG_RULE: rd_val = 32'(valid_q[s]);
                        REG_TYPE: begin
                            for (int unsigned i = 0; i < TYPE_NUM; i++) begin
                                if (idx_ext == i) begin
                                    rd_val[16 +: TYPE_WIDTH] = type_data_q[s][i];
                                    rd_val[0 +: TYPE_WIDTH]  = type_mask_q[s][i];
                                end
                            end
                        end
                        REG_KEY: begin
                            for (int unsigned i = 0; i < KEY_FIELD_NUM; i++) begin
                                if (idx_ext == i) rd_val = 32'(key_off_q[s][i]);
                            end
                        end
                        default: rd_val = '0;
                    endcase
                end
            end
        end
    end

    // Read data holds its value until the next read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_val;
            end
            rvalid_q <= rd_en;
            err_q    <= err_d;
        end
    end

    assign o_rule_rdata         = rdata_q;
    assign o_rule_rvalid        = rvalid_q;
    assign o_rule_err           = err_q;
    assign o_commit_busy        = (state_q != IDLE);
    assign o_commit_done        = (state_q == APPLY);
    assign o_type_offset        = active_q;
    assign o_typeRule_wren      = wren_q;
    assign o_typeRule_valid     = valid_q;
    assign o_typeRule_typeData  = type_data_q;
    assign o_typeRule_typeMask  = type_mask_q;
    assign o_typeRule_keyOffset = key_off_q;

endmodule

// File: tb/tb_rule_conf_bank.sv
// Directed bench for rule_conf_bank: register writes, readback, commit
// handshake, illegal accesses and reset during a pending commit.
module tb_rule_conf_bank;

    localparam int unsigned STAGE_NUM         = 3;
    localparam int unsigned TYPE_OFFSET_WIDTH = 7;
    localparam int unsigned TYPE_NUM          = 4;
    localparam int unsigned TYPE_WIDTH        = 8;
    localparam int unsigned KEY_OFFSET_WIDTH  = 6;
    localparam int unsigned KEY_FIELD_NUM     = 8;
    localparam int unsigned RULE_NUM          = 4;
    localparam logic [31:0] CTRL              = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        wren;
    logic        rden;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic [STAGE_NUM-1:0] stage_idle;
    logic        busy;
    logic        done;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     type_offset;
    logic [STAGE_NUM-1:0][RULE_NUM-1:0]                            rule_wren;
    logic [STAGE_NUM-1:0]                                          rule_valid;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_data;
    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            type_mask;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] key_off;

    logic [STAGE_NUM-1:0][TYPE_NUM-1:0][TYPE_WIDTH-1:0]            exp_td;
    logic [STAGE_NUM-1:0][KEY_FIELD_NUM-1:0][KEY_OFFSET_WIDTH-1:0] exp_ko;

    int n_checks;
    int n_pass;
    logic done_seen;

    rule_conf_bank #(
        .STAGE_NUM         (STAGE_NUM),
        .TYPE_OFFSET_WIDTH (TYPE_OFFSET_WIDTH),
        .TYPE_NUM          (TYPE_NUM),
        .TYPE_WIDTH        (TYPE_WIDTH),
        .KEY_OFFSET_WIDTH  (KEY_OFFSET_WIDTH),
        .KEY_FIELD_NUM     (KEY_FIELD_NUM),
        .RULE_NUM          (RULE_NUM)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_rule_wren          (wren),
        .i_rule_rden          (rden),
        .i_rule_addr          (addr),
        .i_rule_wdata         (wdata),
        .o_rule_rdata         (rdata),
        .o_rule_rvalid        (rvalid),
        .o_rule_err           (err),
        .i_stage_idle         (stage_idle),
        .o_commit_busy        (busy),
        .o_commit_done        (done),
        .o_type_offset        (type_offset),
        .o_typeRule_wren      (rule_wren),
        .o_typeRule_valid     (rule_valid),
        .o_typeRule_typeData  (type_data),
        .o_typeRule_typeMask  (type_mask),
        .o_typeRule_keyOffset (key_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge with the strobe dropped.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wren  = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wren  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        rden = 1'b1;
        addr = a;
        @(negedge clk);
        rden = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        wren       = 1'b0;
        rden       = 1'b0;
        addr       = '0;
        wdata      = '0;
        stage_idle = 3'b111;
        exp_td     = '0;
        exp_ko     = '0;
        repeat (2) @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_offset", type_offset, 0);
        check("rst_rvalid_err", {rvalid, err}, 0);
        check("rst_rule", {rule_wren, rule_valid}, 0);
        rst_n = 1'b1;

        // Shadow write is invisible until committed; readback shows shadow.
        bus_write(32'h0010_0002, 32'h15);
        check("toff_no_commit", type_offset[1][2], 0);
        check("toff_wr_err", err, 0);
        bus_read(32'h0010_0002);
        check("toff_rdata", rdata, 32'h15);
        check("toff_rvalid", rvalid, 1);
        @(negedge clk);
        check("rvalid_pulse", rvalid, 0);
        check("rdata_hold", rdata, 32'h15);

        // Commit waits on stage 1 being idle.
        stage_idle = 3'b101;
        bus_write(CTRL, 32'h2);
        for (int k = 0; k < 5; k++) begin
            check("commit_wait_busy", busy, 1);
            check("commit_wait_done", done, 0);
            @(negedge clk);
        end
        check("commit_wait_off", type_offset[1][2], 0);
        stage_idle = 3'b111;
        @(negedge clk);
        check("apply_done", done, 1);
        check("apply_busy", busy, 1);
        check("apply_off_old", type_offset[1][2], 0);
        @(negedge clk);
        check("commit_off", type_offset[1][2], 7'h15);
        check("commit_busy_clr", {busy, done}, 0);
        bus_read(CTRL);
        check("ctrl_rd", rdata, 32'h2);

        // Type match and rule commit
        bus_write(32'h0022_0001, 32'h00AB_00F0);
        exp_td[2][1] = 8'hAB;
        check("typedata", type_data, exp_td);
        check("typemask", type_mask[2][1], 8'hF0);
        bus_write(32'h0021_0003, 32'h1);
        check("rule_wren", rule_wren, 12'h800);
        check("rule_valid", rule_valid, 3'b100);
        @(negedge clk);
        check("rule_wren_pulse", rule_wren, 0);
        bus_read(32'h0022_0001);
        check("type_rd", rdata, 32'h00AB_00F0);
        bus_read(32'h0021_0003);
        check("rule_rd", rdata, 32'h1);
        bus_write(32'h0013_0007, 32'h2A);
        exp_ko[1][7] = 6'h2A;
        check("keyoff", key_off, exp_ko);
        bus_read(32'h0013_0007);
        check("key_rd", rdata, 32'h2A);

        // Illegal accesses
        bus_write(32'h0052_0000, 32'h00FF_00FF);
        check("bad_stage_err", err, 1);
        check("bad_stage_noeff", type_data, exp_td);
        bus_write(32'h0013_0008, 32'h11);
        check("bad_key_err", err, 1);
        check("bad_key_noeff", key_off, exp_ko);
        bus_write(32'h0000_0000, 32'h33);
        check("good_wr_err", err, 0);
        stage_idle = 3'b000;
        bus_write(CTRL, 32'h1);
        check("commit2_err", err, 0);
        check("commit2_busy", busy, 1);
        bus_write(CTRL, 32'h4);
        check("commit_busy_err", err, 1);
        bus_read(CTRL);
        check("ctrl_rd_busy", rdata, 32'h8000_0001);
        bus_read(32'h0050_0000);
        check("bad_rd_err", err, 1);
        check("bad_rd_data", rdata, 0);

        // Shadow write lands in the APPLY cycle.
        stage_idle = 3'b001;
        @(negedge clk);
        check("apply2_done", done, 1);
        bus_write(32'h0000_0000, 32'h44);
        check("apply_old_shadow", type_offset[0][0], 7'h33);
        check("other_off_kept", type_offset[1][2], 7'h15);
        bus_read(32'h0000_0000);
        check("shadow_new", rdata, 32'h44);
        stage_idle = 3'b111;
        bus_write(CTRL, 32'h1);
        @(negedge clk);
        @(negedge clk);
        check("commit3_off", type_offset[0][0], 7'h44);

        // Reset while waiting abandons the commit.
        stage_idle = 3'b000;
        bus_write(CTRL, 32'h6);
        check("commit4_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_offset", type_offset, 0);
        check("arst_rule", {rule_valid, type_data, type_mask}, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        stage_idle = 3'b111;
        done_seen  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            done_seen = done_seen | done | busy;
        end
        check("post_rst_no_done", done_seen, 0);
        check("post_rst_key", key_off, 0);
        bus_write(CTRL, 32'h0);
        check("zero_mask_err", err, 1);
        check("zero_mask_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
